// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Operand/result bundle for the bit-serial adder sequencer.
//
//   Parameter:
//     WIDTH   operand and sum width in bits
//
//   Signals (master = upstream requester, slave = serial_adder_ctrl):
//     start   master -> slave  request a new operation
//     a, b    master -> slave  operands, captured on the accepting edge
//     cin     master -> slave  carry-in, captured on the accepting edge
//     sub     master -> slave  subtract select (SERIAL_ADDER_SUB_EN only)
//     busy    slave -> master  high while the adder is stepping through bits
//     done    slave -> master  one-cycle pulse when s/cout (and ovf) are new
//     s       slave -> master  sum result register
//     cout    slave -> master  carry-out result register
//     ovf     slave -> master  signed overflow (SERIAL_ADDER_SUB_EN only)
//
//   Handshake: start is sampled on a rising clk edge only while the
//   sequencer is idle or showing done; that edge captures a/b/cin(/sub).
//   busy rises after the accepting edge, and done pulses for exactly one
//   cycle when the result registers have been updated. start seen while
//   busy is ignored.
//
//   Build option: define SERIAL_ADDER_SUB_EN to add sub and ovf.
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, s, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder sequencer. A single 1-bit full-adder stage is reused
//   over WIDTH clock cycles to form {cout, s} = a + b + cin.
//
//   Parameter:
//     WIDTH        operand and sum width (2..16)
//
//   Ports:
//     clk          system clock, rising edge active
//     rst          asynchronous, active-high reset
//     bus          serial_adder_ctrl_if.slave (start/a/b/cin in,
//                  busy/done/s/cout out; sub/ovf with SERIAL_ADDER_SUB_EN)
//     o_dbg_state  current FSM state encoding (0 IDLE, 1 RUN, 2 DONE)
//
//   Build option: SERIAL_ADDER_SUB_EN adds sub (a - b in two's complement)
//   and the signed overflow flag ovf.
//
//   Timing: start accepted at edge E0 -> busy after E0 -> done and new
//   s/cout after edge E(WIDTH). From DONE a new start is accepted directly,
//   giving one result per WIDTH+1 cycles back to back.
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus,
    output logic [1:0]          o_dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_carry;
    logic [WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    // A new operation is only taken when not already stepping bits.
    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_BIT);

    // Shared full-adder stage working on the LSBs of the operand shifters.
    assign w_fa_sum    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_fa_carry  = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    // Sum bits enter from the MSB end so after WIDTH steps bit 0 sits at LSB.
    assign w_work_next = {w_fa_sum, r_work[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
    logic r_ovf;

    // Subtraction is a + ~b + 1; cin is not used in that mode.
    assign w_b_load = bus.sub ? ~bus.b : bus.b;
    assign w_c_load = bus.sub ? 1'b1   : bus.cin;
    assign bus.ovf  = r_ovf;
`else
    assign w_b_load = bus.b;
    assign w_c_load = bus.cin;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = bus.start ? S_RUN : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake flags: registered decodes of the state being entered, so
    // they line up exactly with r_state and are never high together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_RUN);
            r_done <= (w_next == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, carry flop, bit counter, result regs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= w_b_load;
                r_carry <= w_c_load;
                r_work  <= '0;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_fa_carry;
                r_work  <= w_work_next;
                // Counter parks on the last bit so it never wraps mid-op.
                if (!w_last) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                // Result registers change only on the edge entering DONE.
                if (w_last) begin
                    r_s    <= w_work_next;
                    r_cout <= w_fa_carry;
`ifdef SERIAL_ADDER_SUB_EN
                    // r_carry is the carry into the MSB at the final step.
                    r_ovf  <= r_carry ^ w_fa_carry;
`endif
                end
            end
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.s       = r_s;
    assign bus.cout    = r_cout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH = 4). A vector table of
//   operations is replayed through a driver task; expected {ovf, cout, s}
//   words go into a queue at drive time and are popped by a monitor on each
//   done pulse. Hand-written sequences cover start-during-RUN, reset in the
//   middle of an operation and back-to-back operation.
//   Build option: SERIAL_ADDER_SUB_EN adds subtract vectors.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 4;

    // ------------------------------------------------------------------
    // Clock and reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();
    logic [1:0] dbg_state;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [W+1:0] exp_q[$];   // {ovf, cout, s}
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W+1:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: whole-word add with explicit sign-rule overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   full;
        logic         ov;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full};
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub, input logic [W+1:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub; v.exp = exp;
        return v;
    endfunction

    task automatic drive_sub(input logic sub);
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: sub vector ignored in add-only build");
`endif
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops one expected result per done pulse
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (bus.busy || bus.done) begin
            check("busy_done_exclusive", 32'(bus.busy && bus.done), 32'd0);
        end
        if (bus.done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 with s=0x%0h, expected no pending result (t=%0t)",
                         bus.s, $time);
            end else begin
                e = exp_q.pop_front();
                check("result_cout_s", 32'({bus.cout, bus.s}), 32'(e[W:0]));
`ifdef SERIAL_ADDER_SUB_EN
                check("result_ovf", 32'(bus.ovf), 32'(e[W+1]));
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver: one operation with latency and busy-length checks
    // ------------------------------------------------------------------
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input logic [W+1:0] exp, input string tag);
        int  busy_n;
        bit  seen;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        drive_sub(sub);
        bus.start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        // Scramble inputs after the accepting edge; they must not matter.
        bus.start = 1'b0;
        bus.a     = W'($urandom_range(0, (1 << W) - 1));
        bus.b     = W'($urandom_range(0, (1 << W) - 1));
        bus.cin   = 1'($urandom_range(0, 1));
        busy_n = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 3 * W && !seen; k++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                seen = 1'b1;
                check({tag, "_latency"}, 32'(k), 32'(W + 1));
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", tag, 3 * W);
        end
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int dones;
        bit seen;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        drive_sub(1'b0);

        // Reset held with random inputs, then idle hold after release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = W'($urandom_range(0, (1 << W) - 1));
            bus.b     = W'($urandom_range(0, (1 << W) - 1));
            bus.cin   = 1'($urandom_range(0, 1));
            check("reset_outputs", 32'({bus.busy, bus.done, bus.cout, bus.s}), 32'd0);
            check("reset_state", 32'(dbg_state), 32'd0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_hold", 32'({bus.busy, bus.done, bus.cout, bus.s}), 32'd0);
        end
`ifdef SERIAL_ADDER_SUB_EN
        check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif

        // Vector table: {a, b, cin, sub, {ovf, cout, s}}.
        vecs.push_back(mk(4'h5, 4'h3, 1'b0, 1'b0, {1'b1, 1'b0, 4'h8}));
        vecs.push_back(mk(4'hF, 4'h1, 1'b0, 1'b0, {1'b0, 1'b1, 4'h0}));
        vecs.push_back(mk(4'hF, 4'hF, 1'b1, 1'b0, {1'b0, 1'b1, 4'hF}));
        vecs.push_back(mk(4'h0, 4'h0, 1'b1, 1'b0, {1'b0, 1'b0, 4'h1}));
        vecs.push_back(mk(4'hA, 4'h5, 1'b1, 1'b0, {1'b0, 1'b1, 4'h0}));
        vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, {1'b0, 1'b0, 4'h0}));
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back(mk(4'h3, 4'h5, 1'b0, 1'b1, {1'b0, 1'b0, 4'hE}));
        vecs.push_back(mk(4'h8, 4'h1, 1'b0, 1'b1, {1'b1, 1'b1, 4'h7}));
        vecs.push_back(mk(4'h8, 4'h1, 1'b1, 1'b1, {1'b1, 1'b1, 4'h7}));
        vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b1, {1'b0, 1'b1, 4'h0}));
`endif
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            vecs.push_back(mk(ra, rb, rc, rs, model(ra, rb, rc, rs)));
        end
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp, "vec");
        end

        // start during RUN is ignored.
        @(negedge clk);
        bus.a = 4'h2; bus.b = 4'h2; bus.cin = 1'b0; drive_sub(1'b0);
        bus.start = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 4'h4});
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'h9; bus.b = 4'h7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dones = 0;
        for (int k = 0; k < 3 * W; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("ignore_start_done_count", 32'(dones), 32'd1);
        check("ignore_start_s", 32'(bus.s), 32'h4);

        // Reset during the second RUN cycle discards the operation.
        @(negedge clk);
        bus.a = 4'h5; bus.b = 4'h6; bus.cin = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("run_holds_prev_s", 32'(bus.s), 32'h4);
        check("run_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrun_reset_outputs", 32'({bus.busy, bus.done, bus.cout, bus.s}), 32'd0);
        check("midrun_reset_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrun_reset_no_done", 32'(dones), 32'd0);
        do_op(4'h7, 4'h1, 1'b0, 1'b0, {1'b1, 1'b0, 4'h8}, "after_reset");

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        bus.a = 4'h3; bus.b = 4'h4; bus.cin = 1'b0; drive_sub(1'b0);
        bus.start = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 4'h7});
        exp_q.push_back({1'b0, 1'b0, 4'h2});
        @(posedge clk);
        #1;
        bus.a = 4'h1; bus.b = 4'h1;
        seen = 1'b0;
        for (int k = 1; k <= 3 * W && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("b2b_first_done_seen", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int k = 1; k <= 3 * W && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("b2b_no_idle_busy", 32'(bus.busy), 32'd1);
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
                check("b2b_done_spacing", 32'(k), 32'(W + 1));
            end
        end
        check("b2b_second_done_seen", 32'(seen), 32'd1);
        bus.start = 1'b0;

        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer. One shared 1-bit full-adder stage is reused over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in.
- Trades area for latency against the parallel ripple adder.
- Sits between board-level operand capture (switches/registers) and result display (LEDs). Upstream logic controls it with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 2..16).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when s/cout become valid.
- s  output  WIDTH  sum result register.
- cout  output  1  carry-out result register.

Behaviour:
- Clock and reset: single clock domain, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, s=0, cout=0; internal shift registers, carry flop and bit counter all 0.
- FSM has three states:
  - IDLE: start=1 at edge -> load a, b, cin into shift registers, clear counter, go to RUN. Otherwise stay in IDLE.
  - RUN: on each edge, the full-adder stage takes the LSB of each shift register and the carry flop.
    - The sum bit shifts into the working-sum register from the MSB end. Operand registers shift right by 1. The carry flop takes the stage carry-out. The counter increments.
    - When counter==WIDTH-1 on that edge, go to DONE.
    - On the same edge, copy the completed working sum to s and the final carry to cout.
  - DONE: done=1 for exactly this cycle.
    - start=1 -> accept new operands and go to RUN (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Latency: start accepted at edge E0 -> busy=1 after E0 -> done=1 and s/cout valid after edge E(WIDTH). Throughput is one result per WIDTH+1 cycles in back-to-back mode.
- busy is a registered decode of RUN. done is a registered decode of DONE. The two are never high together.
- start in RUN is ignored. Operands and in-progress state are unaffected.
- a, b, cin changing after the accepting edge have no effect on the current operation.
- s and cout hold the last completed result through IDLE and through a subsequent RUN. They update only on the edge entering DONE.
- Arithmetic: {cout, s} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No truncation beyond this.
- Counter width is clog2(WIDTH). The counter does not wrap during an operation and is cleared on every accept.
- Reset mid-RUN: immediately returns to IDLE and clears s and cout to 0. No done pulse. The partial result is discarded.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on the accepting edge.
  - Adds output port ovf (1 bit, reset 0), updated together with s and cout.
  - sub=1: the B shift register loads ~b and the carry flop loads 1 (cin is ignored), computing a-b in two's complement.
  - ovf = signed overflow of the operation: carry into the MSB XOR carry out of the MSB, captured at the final bit.
  - For sub=1, cout=1 means no borrow.
  - sub=0: identical to the base behaviour, with ovf still computed.
- Undefined: sub and ovf ports do not exist. The block is addition only.

Test Plan:
- Reset asserted with random inputs -> busy=0, done=0, s=0, cout=0. After release with start=0, outputs hold indefinitely.
- WIDTH=4, a=4'h5, b=4'h3, cin=0, start pulse -> busy high for 4 cycles, done high for 1 cycle, s=4'h8, cout=0.
- a=4'hF, b=4'h1, cin=0 -> s=4'h0, cout=1. Then a=4'hF, b=4'hF, cin=1 -> s=4'hF, cout=1.
- Start an op with a=4'h2, b=4'h2. Pulse start with a=4'h9 during RUN -> ignored, done once, s=4'h4.
- Assert rst during the 2nd RUN cycle -> immediate IDLE, s=0, no done pulse. Next op a=4'h7, b=4'h1 -> s=4'h8, cout=0.
- start held high through DONE with new a=4'h1, b=4'h1 -> RUN re-entered with no IDLE cycle; second done 5 cycles after the first, s=4'h2. With SERIAL_ADDER_SUB_EN: sub=1, a=4'h3, b=4'h5 -> s=4'hE, cout=0, ovf=0. sub=1, a=4'h8, b=4'h1 -> s=4'h7, ovf=1.
